// File: rtl/morse_rx_fifo_pkg.sv
// morse_rx_fifo_pkg
//   Shared definitions for the Morse receiver:
//   - char_t     : 6-bit output character code
//                  (0-9 digits, 10-35 A-Z, 36 space, 63 invalid)
//   - CH_SPACE   : code pushed for a word gap
//   - CH_INVALID : code for an unrecognised or over-long character
//   - state_t    : receiver FSM states
package morse_rx_fifo_pkg;

  typedef logic [5:0] char_t;

  localparam char_t CH_SPACE   = 6'd36;
  localparam char_t CH_INVALID = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/morse_rx_fifo_lut.sv
// morse_lut
//   Purely combinational Morse decoder. Symbol k of a character sits at
//   code bit 4-k (dot = 0, dash = 1), so only the top len bits are looked at.
//   Ports:
//     code [4:0] in  : symbol pattern, first symbol in bit 4
//     len  [2:0] in  : number of symbols (1..5 are decodable)
//     ch   [5:0] out : decoded character, CH_INVALID for unlisted patterns
module morse_lut
  import morse_rx_fifo_pkg::*;
(
  input  logic [4:0] code,
  input  logic [2:0] len,
  output char_t      ch
);

  always_comb begin
    ch = CH_INVALID;
    case (len)
      3'd1: ch = code[4] ? 6'd29 : 6'd14;
      3'd2: begin
        case (code[4:3])
          2'b00:   ch = 6'd18;
          2'b01:   ch = 6'd10;
          2'b10:   ch = 6'd23;
          default: ch = 6'd22;
        endcase
      end
      3'd3: begin
        case (code[4:2])
          3'b000:  ch = 6'd28;
          3'b001:  ch = 6'd30;
          3'b010:  ch = 6'd27;
          3'b011:  ch = 6'd32;
          3'b100:  ch = 6'd13;
          3'b101:  ch = 6'd20;
          3'b110:  ch = 6'd16;
          default: ch = 6'd24;
        endcase
      end
      3'd4: begin
        case (code[4:1])
          4'b0000: ch = 6'd17;
          4'b0001: ch = 6'd31;
          4'b0010: ch = 6'd15;
          4'b0100: ch = 6'd21;
          4'b0110: ch = 6'd25;
          4'b0111: ch = 6'd19;
          4'b1000: ch = 6'd11;
          4'b1001: ch = 6'd33;
          4'b1010: ch = 6'd12;
          4'b1011: ch = 6'd34;
          4'b1100: ch = 6'd35;
          4'b1101: ch = 6'd26;
          default: ch = CH_INVALID;
        endcase
      end
      3'd5: begin
        case (code)
          5'b01111: ch = 6'd1;
          5'b00111: ch = 6'd2;
          5'b00011: ch = 6'd3;
          5'b00001: ch = 6'd4;
          5'b00000: ch = 6'd5;
          5'b10000: ch = 6'd6;
          5'b11000: ch = 6'd7;
          5'b11100: ch = 6'd8;
          5'b11110: ch = 6'd9;
          5'b11111: ch = 6'd0;
          default:  ch = CH_INVALID;
        endcase
      end
      default: ch = CH_INVALID;
    endcase
  end

endmodule

// File: rtl/morse_rx_fifo.sv
// morse_rx_fifo
//   Morse receiver: measures key-high runs (dot/dash) and key-low gaps
//   (character end / word end), decodes each character and queues it in a
//   first-word-fall-through FIFO.
//   Ports:
//     clk      in  : rising-edge clock
//     rst      in  : asynchronous active-high reset
//     key      in  : synchronised, debounced key level (1 = pressed)
//     rd_en    in  : pop request, ignored while empty
//     rd_data  out : FIFO head (6-bit character code)
//     empty    out : FIFO holds no entries
//     full     out : FIFO holds DEPTH entries
//     count    out : entries held
//     overflow out : sticky, a push was dropped
//     busy     out : FSM not idle
module morse_rx_fifo
  import morse_rx_fifo_pkg::*;
#(
  parameter int DOT_MAX  = 3,
  parameter int CHAR_GAP = 8,
  parameter int WORD_GAP = 24,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key,
  input  logic                     rd_en,
  output char_t                    rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CMAX = (WORD_GAP > DOT_MAX + 1) ? WORD_GAP : DOT_MAX + 1;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]   ONE       = CW'(1);
  localparam logic [CW-1:0]   DOT_LIM   = CW'(DOT_MAX);
  localparam logic [CW-1:0]   PRESS_SAT = CW'(DOT_MAX + 1);
  localparam logic [CW-1:0]   GAP_END   = CW'(CHAR_GAP);
  localparam logic [CW-1:0]   IDLE_SAT  = CW'(WORD_GAP);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   press_q, press_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic [4:0]      code_q, code_d;
  logic [2:0]      len_q, len_d;
  logic            too_long_q, too_long_d;

  logic            push;
  char_t           push_char;
  char_t           lut_char;

  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CNTW-1:0] count_q;
  logic            overflow_q;
  char_t           head_hold;
  char_t           last_char;
  logic            pushed_any;
  char_t           mem [DEPTH];

  logic            pop;
  logic            wr_ok;

  morse_lut u_lut (
    .code (code_q),
    .len  (len_q),
    .ch   (lut_char)
  );

  // Receiver state and all timing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      press_q    <= '0;
      gap_q      <= '0;
      idle_q     <= '0;
      code_q     <= '0;
      len_q      <= '0;
      too_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      press_q    <= press_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
      code_q     <= code_d;
      len_q      <= len_d;
      too_long_q <= too_long_d;
    end
  end

  // Next-state logic. A symbol is classified on the falling key edge; a
  // character is committed on the cycle its gap counter reaches CHAR_GAP;
  // a space is requested on the cycle the idle counter reaches WORD_GAP.
  always_comb begin
    state_d    = state_q;
    press_d    = press_q;
    gap_d      = gap_q;
    idle_d     = idle_q;
    code_d     = code_q;
    len_d      = len_q;
    too_long_d = too_long_q;
    push       = 1'b0;
    push_char  = CH_INVALID;
    case (state_q)
      ST_IDLE: begin
        if (key) begin
          state_d = ST_PRESS;
          press_d = ONE;
        end else if (idle_q != IDLE_SAT) begin
          idle_d = idle_q + ONE;
          // Only one space per word gap, and never before the first char.
          if ((idle_q + ONE == IDLE_SAT) && pushed_any && (last_char != CH_SPACE)) begin
            push      = 1'b1;
            push_char = CH_SPACE;
          end
        end
      end
      ST_PRESS: begin
        if (key) begin
          if (press_q != PRESS_SAT) press_d = press_q + ONE;
        end else begin
          // Past five symbols the code is frozen and the char becomes invalid.
          if (len_q == 3'd5) begin
            too_long_d = 1'b1;
          end else begin
            code_d[3'd4 - len_q] = (press_q > DOT_LIM);
            len_d                = len_q + 3'd1;
          end
          state_d = ST_GAP;
          gap_d   = ONE;
        end
      end
      ST_GAP: begin
        if (key) begin
          state_d = ST_PRESS;
          press_d = ONE;
          gap_d   = '0;
        end else if (gap_q + ONE == GAP_END) begin
          push       = 1'b1;
          push_char  = too_long_q ? CH_INVALID : lut_char;
          code_d     = '0;
          len_d      = '0;
          too_long_d = 1'b0;
          idle_d     = '0;
          gap_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          gap_d = gap_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop frees a slot before the push is considered, so a full FIFO can
  // accept a commit in the same cycle it is read.
  assign pop   = rd_en && (count_q != '0);
  assign wr_ok = push && ((count_q != DEPTH_C) || pop);

  // FIFO pointers, occupancy, sticky overflow and word-gap bookkeeping.
  // head_hold remembers the last head so rd_data stays stable once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_hold  <= '0;
      last_char  <= '0;
      pushed_any <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        head_hold <= mem[rd_ptr];
      end
      if (wr_ok) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_char  <= push_char;
        pushed_any <= 1'b1;
      end
      if (push && !wr_ok) overflow_q <= 1'b1;
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_char;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE);
  assign rd_data  = empty ? head_hold : mem[rd_ptr];

endmodule

// File: tb/tb_morse_rx_fifo.sv
// tb_morse_rx_fifo
//   Directed bench for morse_rx_fifo with default parameters
//   (DOT_MAX=3, CHAR_GAP=8, WORD_GAP=24, DEPTH=8).
module tb_morse_rx_fifo;

  logic       clk;
  logic       rst;
  logic       key;
  logic       rd_en;
  logic [5:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       busy;

  int total;
  int bad;

  morse_rx_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .busy     (busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic key;
    logic rd;
    int   n;
    int   cnt;
    int   data;
    logic emp;
    logic busy;
  } vec_t;

  vec_t vecs [16];

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int e_cnt, input int e_data,
                             input bit e_emp, input bit e_full, input bit e_ovf,
                             input bit e_busy, input bit chk_data);
    checkVal({tag, ".count"}, int'(count), e_cnt);
    checkVal({tag, ".empty"}, int'(empty), int'(e_emp));
    checkVal({tag, ".full"}, int'(full), int'(e_full));
    checkVal({tag, ".overflow"}, int'(overflow), int'(e_ovf));
    checkVal({tag, ".busy"}, int'(busy), int'(e_busy));
    if (chk_data) checkVal({tag, ".rd_data"}, int'(rd_data), e_data);
  endtask

  // Holds key/rd_en for n rising edges; returns 1 unit after the last edge.
  task automatic applyStimulus(input logic k, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      key   = k;
      rd_en = r;
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
  endtask

  // Keys one character; syms[k] is symbol k (1 = dash). Ends on its commit edge.
  task automatic sendChar(input logic [5:0] syms, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, syms[k] ? 5 : 2);
      applyStimulus(1'b0, 1'b0, (k == n - 1) ? 8 : 2);
    end
  endtask

  task automatic doReset(input string tag);
    rst   = 1'b1;
    key   = 1'b0;
    rd_en = 1'b0;
    #1;
    checkOutput({tag, "_async"}, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    key   = 1'b0;
    rd_en = 1'b0;

    //            key rd  n  cnt data emp busy
    vecs[0]  = '{1'b1, 1'b0, 2, 0,  0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 7, 0,  0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1, 1, 14, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1, 0, 14, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2, 0, 14, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2, 0, 14, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 5, 0, 14, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8, 1, 10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1, 0, 10, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3, 0, 10, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8, 1, 14, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4, 1, 14, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8, 2, 14, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1, 1, 29, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1, 0, 29, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1, 0, 29, 1'b1, 1'b0};

    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // E, A, dot/dash boundary, T, pops and pop-while-empty.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].key, vecs[i].rd, vecs[i].n);
      checkOutput($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].data,
                  vecs[i].emp, 1'b0, 1'b0, vecs[i].busy, 1'b1);
    end

    // Five-symbol digits.
    sendChar(6'b011111, 5);
    checkOutput("digit0", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    sendChar(6'b000000, 5);
    checkOutput("digit5", 1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    sendChar(6'b011110, 5);
    checkOutput("digit1", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("digit_drain", 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Over-long character, then a single word-gap space.
    sendChar(6'b000000, 6);
    checkOutput("toolong", 1, 63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 23);
    checkOutput("space_early", 1, 63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("space_push", 2, 63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("space_head", 1, 36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 30);
    checkOutput("space_once", 1, 36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("space_drain", 0, 36, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill, overflow, commit-with-pop on full, then drain across the wrap.
    doReset("rst_full");
    for (int i = 0; i < 8; i++) sendChar(6'b000000, 1);
    checkOutput("fill8", 8, 14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sendChar(6'b000000, 1);
    checkOutput("fill9", 8, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 7);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("pop_push_full", 8, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("drain%0d.rd_data", i), int'(rd_data), (i < 7) ? 14 : 29);
      applyStimulus(1'b0, 1'b1, 1);
    end
    checkOutput("drained", 0, 29, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-PRESS discards the partial character.
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("mid_press", 0, 29, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    doReset("rst_press");
    checkOutput("post_rst_press", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 30);
    checkOutput("no_push_press", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-GAP discards the partial character.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("mid_gap", 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    doReset("rst_gap");
    applyStimulus(1'b0, 1'b0, 30);
    checkOutput("no_push_gap", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Receiver still decodes after a mid-character reset.
    sendChar(6'b000001, 1);
    checkOutput("after_rst_T", 1, 29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_rx_fifo.md
MORSE_RX_FIFO -- requirements
Module: morse_rx_fifo

Interface
REQ-001 SHALL have parameter DOT_MAX, default 3: longest key-high run, in cycles, classified as dot; longer runs are dashes.
REQ-002 SHALL have parameter CHAR_GAP, default 8: key-low cycles that end a character.
REQ-003 SHALL have parameter WORD_GAP, default 24 (> CHAR_GAP): key-low cycles in IDLE that insert a space.
REQ-004 SHALL have parameter DEPTH, default 8: output FIFO entries, power of two, >= 2.
REQ-005 One clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 key  in  1  synchronised, debounced key level; 1 = pressed.
REQ-008 rd_en  in  1  pop request; ignored when empty.
REQ-009 rd_data  out  6  FIFO head (first-word-fall-through); 0-9 digits, 10-35 A-Z, 36 space, 63 invalid.
REQ-010 empty  out  1  FIFO holds no entries.
REQ-011 full  out  1  FIFO holds DEPTH entries.
REQ-012 count  out  $clog2(DEPTH)+1  entries held.
REQ-013 overflow  out  1  sticky; a push was dropped.
REQ-014 busy  out  1  FSM not in IDLE.

Function
REQ-015 FSM states IDLE, PRESS, GAP; busy = (state != IDLE).
REQ-016 IDLE, key=1 -> PRESS, press counter = 1; IDLE, key=0 -> idle counter increments, saturating at WORD_GAP.
REQ-017 PRESS, key=1 -> press counter increments, saturating at DOT_MAX+1.
REQ-018 PRESS, key=0 -> symbol = (press counter > DOT_MAX) dash=1 : dot=0; -> GAP, gap counter = 1.
REQ-019 Symbol k (k=0 first) stored at code bit 4-k; sym_len increments; a 6th or later symbol sets too_long, code unchanged.
REQ-020 GAP, key=1 -> PRESS, press counter = 1, gap counter cleared.
REQ-021 GAP, gap counter reaching CHAR_GAP -> commit: push decoded char (63 if too_long), clear code/sym_len/too_long/idle counter, -> IDLE.
REQ-022 Decode by length: 1 E=14/T=29; 2 I,A,N,M; 3 S,U,R,W,D,K,G,O; 4 H,V,F,L,P,J,B,X,C,Y,Z,Q; 5 digits (01111=1 ... 00000=5 ... 11111=0); any unlisted pattern -> 63.
REQ-023 Idle counter reaching WORD_GAP pushes 36 once, only if the last pushed char was not 36 and at least one char has been pushed since reset.
REQ-024 Pushed char visible at rd_data, empty low, the cycle after commit.
REQ-025 Pop evaluated before push: rd_en with full and simultaneous commit -> both occur, count unchanged.
REQ-026 Push while full without pop -> entry dropped, contents intact, overflow = 1 until reset.
REQ-027 Read and write pointers wrap modulo DEPTH; count tracks exactly.
REQ-028 rd_en while empty -> no state change; rd_data holds last head value.

Reset
REQ-029 rst asserted -> state IDLE, all counters 0, code 0, sym_len 0, too_long 0, FIFO pointers 0, empty=1, full=0, count=0, overflow=0, busy=0, rd_data=0.
REQ-030 rst mid-PRESS or mid-GAP discards the partial character; no push follows release.
REQ-031 FIFO storage need not be reset; rd_data SHALL read 0 while empty after reset.

Structure
REQ-032 Shared package holds char codes (CH_SPACE=36, CH_INVALID=63), FSM state enum, 6-bit char typedef.
REQ-033 Sub-module morse_lut: combinational (code[4:0], len[2:0]) -> char[5:0] per REQ-022; FIFO is inline.

Verification (DOT_MAX=3, CHAR_GAP=8, WORD_GAP=24, DEPTH=8)
REQ-034 key high 2, low 8 -> one push, rd_data=14 (E), count=1.
REQ-035 key high 2, low 2, high 5, low 8 -> rd_data=10 (A); then 5 dashes -> 0; 5 dots -> 5.
REQ-036 six dots then low 8 -> rd_data=63; then low 24 more -> 36 pushed once, not repeated.
REQ-037 nine E chars, no reads -> full=1, count=8, overflow=1, eight entries of 14 retained; then commit with rd_en on the commit cycle -> count stays 8, overflow still 1.
REQ-038 rst mid-PRESS (key high 2) then key low 30 -> empty=1, no push, overflow=0.
